// File: rtl/seq_detect_ctrl.sv
// Word-to-serial pattern detection controller: accepts a word, scans it
// MSB-first through a programmable matcher, and reports matches per word.
module seq_detect_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PAT_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PAT_W-1:0]        cfg_pattern,
  input  logic [$clog2(PAT_W):0]  cfg_len,
  input  logic                    cfg_overlap,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    det,
  output logic                    done,
  output logic [CNT_W-1:0]        match_cnt
);

  localparam int unsigned LEN_W = $clog2(PAT_W) + 1;
  localparam int unsigned IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [DATA_W-1:0]  word_q;
  logic [PAT_W-1:0]   pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [PAT_W-1:0]   hist_q;
  logic [LEN_W-1:0]   fill_q;
  logic [IDX_W-1:0]   idx_q;

  logic               accept;
  logic               last_bit;
  logic [PAT_W-1:0]   hist_n;
  logic [LEN_W-1:0]   fill_inc;
  logic [PAT_W-1:0]   mask;
  logic               match;
  logic [LEN_W-1:0]   len_clamped;
  logic               in_ready_d;
  logic               bit_valid_d;
  logic               done_d;
  logic               det_d;

  assign accept      = (state_q == S_IDLE) && in_ready && in_valid;
  assign last_bit    = (idx_q == IDX_W'(DATA_W - 1));
  assign len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;

  // Match evaluation against the history as it will be after this edge
  always_comb begin
    mask     = '0;
    hist_n   = PAT_W'({hist_q, bit_out});
    fill_inc = (fill_q >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill_q + LEN_W'(1);
    for (int i = 0; i < int'(PAT_W); i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    match = (state_q == S_SHIFT) && (len_q != '0) && (fill_inc >= len_q) &&
            ((hist_n & mask) == (pat_q & mask));
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (accept)   state_n = S_SHIFT;
      S_SHIFT: if (last_bit) state_n = S_DONE;
      S_DONE:                state_n = S_IDLE;
      default:               state_n = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    in_ready_d  = 1'b0;
    bit_valid_d = 1'b0;
    done_d      = 1'b0;
    det_d       = 1'b0;
    in_ready_d  = (state_n == S_IDLE);
    bit_valid_d = (state_n == S_SHIFT);
    done_d      = (state_n == S_DONE);
    det_d       = match;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      det       <= 1'b0;
      done      <= 1'b0;
      match_cnt <= '0;
      word_q    <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      hist_q    <= '0;
      fill_q    <= '0;
      idx_q     <= '0;
    end else begin
      in_ready  <= in_ready_d;
      bit_valid <= bit_valid_d;
      done      <= done_d;
      det       <= det_d;
      if (accept) begin
        word_q    <= in_data;
        bit_out   <= in_data[DATA_W-1];
        pat_q     <= cfg_pattern;
        len_q     <= len_clamped;
        ovl_q     <= cfg_overlap;
        hist_q    <= '0;
        fill_q    <= '0;
        match_cnt <= '0;
        idx_q     <= '0;
      end else if (state_q == S_SHIFT) begin
        hist_q  <= hist_n;
        fill_q  <= (match && !ovl_q) ? '0 : fill_inc;
        idx_q   <= idx_q + IDX_W'(1);
        word_q  <= {word_q[DATA_W-2:0], 1'b0};
        bit_out <= last_bit ? 1'b0 : word_q[DATA_W-2];
        if (match && (match_cnt != '1)) begin
          match_cnt <= match_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed and random words against a
// reference matcher; a second instance with CNT_W=2 covers saturation.
module tb_seq_detect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_pattern;
  logic [2:0]  cfg_len;
  logic        cfg_overlap;
  logic        in_valid;
  logic [15:0] in_data;

  logic        in_ready, bit_out, bit_valid, det, done;
  logic [7:0]  match_cnt;
  logic        s_in_ready, s_bit_out, s_bit_valid, s_det, s_done;
  logic [1:0]  s_match_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .bit_out(bit_out), .bit_valid(bit_valid), .det(det),
    .done(done), .match_cnt(match_cnt)
  );

  seq_detect_ctrl #(.DATA_W(16), .PAT_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .bit_out(s_bit_out), .bit_valid(s_bit_valid), .det(s_det),
    .done(s_done), .match_cnt(s_match_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan the bit stream, a match needs len bits since the last
  // consumed window (non-overlap) that equal the pattern's low len bits.
  function automatic void model(input logic [15:0] w, input logic [3:0] pat,
                                input logic [2:0] len_in, input bit ovl,
                                output logic [15:0] md, output int cnt);
    int len;
    int start;
    bit ok;
    len = (int'(len_in) > 4) ? 4 : int'(len_in);
    md = '0;
    cnt = 0;
    start = 0;
    for (int k = 0; k < 16; k++) begin
      if (len != 0 && (k - start + 1) >= len) begin
        ok = 1'b1;
        for (int j = 0; j < len; j++) begin
          if (w[15 - (k - j)] != pat[j]) ok = 1'b0;
        end
        if (ok) begin
          md[k] = 1'b1;
          cnt++;
          if (!ovl) start = k + 1;
        end
      end
    end
  endfunction

  task automatic run_word(input logic [15:0] w, input logic [3:0] pat,
                          input logic [2:0] len, input bit ovl, input bit hold,
                          input string name, output int waited);
    logic [15:0] md;
    int cnt, ec, es, dets;
    model(w, pat, len, ovl, md, cnt);
    ec = (cnt > 255) ? 255 : cnt;
    es = (cnt > 3) ? 3 : cnt;
    in_data = w; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 100) begin
      cyc();
      waited++;
    end
    chk({name, " ready_before_accept"}, 32'(in_ready), 1);
    cyc();
    in_valid = hold;
    dets = 0;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s bit_valid[%0d]", name, k), 32'(bit_valid), 1);
      chk($sformatf("%s bit_out[%0d]", name, k), 32'(bit_out), 32'(w[15-k]));
      chk($sformatf("%s det[%0d]", name, k), 32'(det), (k == 0) ? 0 : 32'(md[k-1]));
      chk($sformatf("%s s_det[%0d]", name, k), 32'(s_det), (k == 0) ? 0 : 32'(md[k-1]));
      chk($sformatf("%s done_low[%0d]", name, k), 32'(done), 0);
      chk($sformatf("%s ready_low[%0d]", name, k), 32'(in_ready), 0);
      dets += int'(det);
      if (k == 8) begin
        in_data = 16'($urandom);
        cfg_pattern = 4'($urandom);
        cfg_len = 3'($urandom);
        cfg_overlap = 1'($urandom);
      end
      cyc();
    end
    dets += int'(det);
    chk({name, " done"}, 32'(done), 1);
    chk({name, " s_done"}, 32'(s_done), 1);
    chk({name, " done_bit_valid"}, 32'(bit_valid), 0);
    chk({name, " done_det"}, 32'(det), 32'(md[15]));
    chk({name, " done_ready"}, 32'(in_ready), 0);
    chk({name, " det_pulses"}, 32'(dets), 32'(cnt));
    chk({name, " match_cnt"}, 32'(match_cnt), 32'(ec));
    chk({name, " s_match_cnt"}, 32'(s_match_cnt), 32'(es));
    cyc();
    chk({name, " idle_ready"}, 32'(in_ready), 1);
    chk({name, " idle_done"}, 32'(done), 0);
    chk({name, " idle_det"}, 32'(det), 0);
    chk({name, " held_cnt"}, 32'(match_cnt), 32'(ec));
    chk({name, " s_held_cnt"}, 32'(s_match_cnt), 32'(es));
  endtask

  initial begin
    int w;
    rst = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0;

    // Reset state
    cyc(); cyc();
    chk("rst in_ready", 32'(in_ready), 0);
    chk("rst bit_out", 32'(bit_out), 0);
    chk("rst bit_valid", 32'(bit_valid), 0);
    chk("rst det", 32'(det), 0);
    chk("rst done", 32'(done), 0);
    chk("rst match_cnt", 32'(match_cnt), 0);
    rst = 1'b1;
    chk("rel ready_low", 32'(in_ready), 0);
    cyc();
    chk("rel ready_high", 32'(in_ready), 1);

    // Directed words
    run_word(16'hB600, 4'b1011, 3'd4, 1'b1, 1'b0, "b600_ovl", w);
    run_word(16'hB600, 4'b1011, 3'd4, 1'b0, 1'b0, "b600_novl", w);
    run_word(16'hFFFF, 4'b1111, 3'd4, 1'b1, 1'b0, "ffff_ovl", w);
    run_word(16'hFFFF, 4'b1111, 3'd4, 1'b0, 1'b0, "ffff_novl", w);
    run_word(16'h5600, 4'b1011, 3'd4, 1'b1, 1'b0, "5600", w);
    run_word(16'hB600, 4'b1011, 3'd0, 1'b1, 1'b0, "len0", w);
    run_word(16'hFFFF, 4'b0001, 3'd1, 1'b1, 1'b0, "sat_len1", w);
    run_word(16'hB600, 4'b1011, 3'd7, 1'b1, 1'b0, "clamp7", w);

    // Asynchronous reset in SHIFT cycle 5
    in_data = 16'hB600; cfg_pattern = 4'b1011; cfg_len = 3'd4; cfg_overlap = 1'b1;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("pre_rst match_cnt", 32'(match_cnt), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst bit_valid", 32'(bit_valid), 0);
    chk("midrst det", 32'(det), 0);
    chk("midrst match_cnt", 32'(match_cnt), 0);
    chk("midrst s_match_cnt", 32'(s_match_cnt), 0);
    chk("midrst in_ready", 32'(in_ready), 0);
    chk("midrst bit_out", 32'(bit_out), 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("inrst done[%0d]", k), 32'(done), 0);
    end
    rst = 1'b1;
    chk("rel2 ready_low", 32'(in_ready), 0);
    cyc();
    chk("rel2 ready_high", 32'(in_ready), 1);
    run_word(16'hB600, 4'b1011, 3'd4, 1'b0, 1'b0, "after_rst", w);

    // Back-to-back with in_valid held high
    run_word(16'hFFFF, 4'b1111, 3'd4, 1'b0, 1'b1, "b2b_first", w);
    run_word(16'h5600, 4'b1011, 3'd4, 1'b1, 1'b0, "b2b_second", w);
    chk("b2b accepted_first_idle", 32'(w), 0);

    // Random words
    for (int r = 0; r < 20; r++) begin
      run_word(16'($urandom), 4'($urandom), 3'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom), $sformatf("rnd%0d", r), w);
    end
    in_valid = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Controller that streams parallel words bit-serially through a programmable pattern matcher and counts detections per word. It accepts a word over a valid/ready handshake and latches the pattern configuration with it. It then shifts the word MSB-first, one bit per clock, raising a detect pulse on each match. When the word is finished it reports the match count with a done pulse. It sits between a word-level producer and downstream logic that needs serial sequence detection, such as frame-marker search.

Parameters:
DATA_W, 16, bits per input word; shifted MSB-first.
PAT_W, 4, maximum pattern length in bits.
CNT_W, 8, width of the per-word match counter.

Ports:
clk  input  1  system clock; all flops rising-edge.
rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
cfg_pattern  input  PAT_W  pattern bits; bit [len-1] is the first bit expected, bit 0 the last.
cfg_len  input  $clog2(PAT_W)+1  active pattern length; 0 disables detection; values above PAT_W clamp to PAT_W.
cfg_overlap  input  1  1 = overlapping matches counted; 0 = non-overlapping.
in_valid  input  1  producer has a word on in_data.
in_ready  output  1  controller can accept a word (registered).
in_data  input  DATA_W  word to scan.
bit_out  output  1  serial bit currently being scanned.
bit_valid  output  1  bit_out is valid (high only in SHIFT).
det  output  1  registered one-cycle pulse per match.
done  output  1  one-cycle pulse: word finished, match_cnt is final.
match_cnt  output  CNT_W  matches in the current or last word.

Behaviour:
- Reset values (rst=0): state IDLE; in_ready=0; bit_out=0; bit_valid=0; det=0; done=0; match_cnt=0. History and fill counter are cleared.
- in_ready goes to 1 on the first clk edge after rst is released.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - An accept is in_valid & in_ready at a clk edge.
  - On accept, latch in_data, cfg_pattern, cfg_len (clamped) and cfg_overlap.
  - On accept, clear history, fill counter, match_cnt and bit index.
  - On accept, set in_ready=0 and go to SHIFT.
- SHIFT (exactly DATA_W cycles):
  - Cycle k (0..DATA_W-1) drives bit_out = latched word bit [DATA_W-1-k], with bit_valid=1.
  - At the closing edge the history shifts left with bit_out entering at bit 0.
  - At the same edge fill = min(fill+1, PAT_W).
- Match rule: match when len≠0, fill_next ≥ len, and history_next[len-1:0] == pattern[len-1:0].
- On a match:
  - det is registered high for the following cycle only.
  - match_cnt increments at the same edge, saturating at 2^CNT_W-1.
  - If cfg_overlap=0, fill resets to 0 at that edge; if cfg_overlap=1, fill is kept.
- After the last bit's edge, go to DONE.
- DONE (1 cycle):
  - done=1 and bit_valid=0.
  - det may be high here if the last bit completed a match.
  - match_cnt is final.
  - Next edge: IDLE with in_ready=1.
- Latency:
  - Accept edge → first bit_valid in the next cycle.
  - Accept → done is DATA_W+1 cycles.
  - Minimum accept-to-accept spacing is DATA_W+2 cycles.
- match_cnt holds its value after DONE until the next accept.
- in_data and cfg_* changes outside the accept edge are ignored.
- det is never asserted in IDLE except in the single cycle after DONE is impossible. Det is always registered off the last SHIFT edge, so it lands only in a SHIFT cycle or in DONE.
- Reset mid-word: all outputs drop to their reset values immediately. The partial word and count are discarded, and no done is issued.

Test Plan:
1. pattern=4'b1011, len=4, overlap=1, word 16'hB600 -> det in SHIFT cycles 4 and 7; done at cycle 17 with match_cnt=2. Same word with overlap=0 -> det only in cycle 4, match_cnt=1.
2. pattern=4'b1111, len=4, word 16'hFFFF -> overlap=1 gives match_cnt=13; overlap=0 gives match_cnt=4 (det in cycles 4, 8, 12 and 16, the last coinciding with done).
3. pattern=4'b1011, word 16'h5600 (stream 0101011…) -> single det in cycle 7, match_cnt=1. Then a word with len=0 -> no det, match_cnt=0.
4. Drive rst=0 asynchronously during SHIFT cycle 5 -> bit_valid, det and match_cnt go to 0 immediately, no done. After release, in_ready=1 one edge later and a fresh word scans correctly.
5. Hold in_valid=1 with two words back-to-back, changing in_data mid-scan -> in_ready stays low through SHIFT/DONE, the mid-scan value is ignored, and the second word is accepted in the first IDLE cycle.
6. CNT_W=2, pattern=1'b1, len=1, word 16'hFFFF -> match_cnt saturates at 3 while det pulses 16 times. Then cfg_len=7 with PAT_W=4 -> clamped to 4.
